// File: rtl/scan_pkg.sv
// Shared definitions for the transducer scan path: sequencer states, default grid size
// and the constants that map a grid element onto the mux plex/input lines.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM,
        WRITE
    } scan_state_t;

    localparam int DEFAULT_ROWS         = 7;
    localparam int DEFAULT_COLS         = 7;
    localparam int PLEX_BASE            = 3;
    localparam int ODD_ROW_INPUT_OFFSET = 9;

endpackage

// File: rtl/element_map.sv
// Combinational mapping from a grid element (row, col) to the mux plex/input selects.
// Shared with the display path so both sides agree on which element is addressed.
module element_map
    import scan_pkg::*;
(
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic [1:0] uplex,
    output logic [3:0] uinput
);

    // Two rows share a plex; odd rows sit on the upper half of the input bank.
    always_comb begin
        uplex  = 2'(PLEX_BASE - int'(row >> 1));
        uinput = 4'(int'(col) + (row[0] ? ODD_ROW_INPUT_OFFSET : 0));
    end

endmodule

// File: rtl/scan_sequencer.sv
// Walks every grid element: settle, integrate the mixer product, then write one scaled,
// saturated intensity word per element into the frame store.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int ROWS          = DEFAULT_ROWS,
    parameter int COLS          = DEFAULT_COLS,
    parameter int SETTLE_CYCLES = 256,
    parameter int ACCUM_CYCLES  = 1200,
    parameter int DATA_W        = 16,
    parameter int ACC_W         = 32,
    parameter int SHIFT         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [DATA_W-1:0] mixed,
    output logic [2:0]        row,
    output logic [2:0]        col,
    output logic [1:0]        uplex,
    output logic [3:0]        uinput,
    output logic              wr_en,
    output logic [5:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAX_CNT = (SETTLE_CYCLES > ACCUM_CYCLES) ? SETTLE_CYCLES : ACCUM_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             stop_pending;

    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_next;
    logic             last_col;
    logic             last_elem;

    // Drop the fraction bits, then clamp to the widest word the frame store accepts.
    function automatic logic [DATA_W-1:0] scale(input logic [ACC_W-1:0] a);
        logic [ACC_W+DATA_W-1:0] wide;
        wide = {{DATA_W{1'b0}}, a} >> SHIFT;
        if (wide > {{ACC_W{1'b0}}, {DATA_W{1'b1}}})
            scale = '1;
        else
            scale = wide[DATA_W-1:0];
    endfunction

    always_comb begin
        acc_sum   = {1'b0, acc} + (ACC_W + 1)'(mixed);
        acc_next  = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        last_col  = (col == 3'(COLS - 1));
        last_elem = last_col && (row == 3'(ROWS - 1));
    end

    element_map u_element_map (
        .row    (row),
        .col    (col),
        .uplex  (uplex),
        .uinput (uinput)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            cnt          <= '0;
            acc          <= '0;
            stop_pending <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    stop_pending <= 1'b0;
                    if (start && !stop) begin
                        state <= SETTLE;
                        row   <= '0;
                        col   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (stop)
                        stop_pending <= 1'b1;
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt   <= '0;
                        acc   <= '0;
                        state <= ACCUM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACCUM: begin
                    if (stop)
                        stop_pending <= 1'b1;
                    acc <= acc_next;
                    if (cnt == CNT_W'(ACCUM_CYCLES - 1)) begin
                        cnt        <= '0;
                        state      <= WRITE;
                        wr_en      <= 1'b1;
                        wr_addr    <= 6'(int'(row) * COLS + int'(col));
                        wr_data    <= scale(acc_next);
                        frame_done <= last_elem;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    cnt <= '0;
                    if (last_elem) begin
                        row <= '0;
                        col <= '0;
                    end else if (last_col) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                    // A stop seen on this very cycle still counts as pending.
                    if (stop_pending || stop || (last_elem && !continuous)) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        stop_pending <= 1'b0;
                    end else begin
                        state <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: several parameterisations share one stimulus stream and are
// compared against a position-based model of the element schedule.
module tb_scan_sequencer;

    localparam int NI = 4;
    localparam int P_ROWS [NI] = '{2, 2, 2, 7};
    localparam int P_COLS [NI] = '{3, 3, 3, 7};
    localparam int P_S    [NI] = '{4, 4, 4, 2};
    localparam int P_A    [NI] = '{8, 8, 8, 3};
    localparam int P_SH   [NI] = '{2, 0, 2, 1};
    localparam int P_ACCW [NI] = '{32, 32, 18, 32};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] mixed = '0;

    logic [2:0]  o_row     [NI];
    logic [2:0]  o_col     [NI];
    logic [1:0]  o_uplex   [NI];
    logic [3:0]  o_uinput  [NI];
    logic        o_wr_en   [NI];
    logic [5:0]  o_wr_addr [NI];
    logic [15:0] o_wr_data [NI];
    logic        o_busy    [NI];
    logic        o_fd      [NI];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        scan_sequencer #(
            .ROWS          (P_ROWS[i]),
            .COLS          (P_COLS[i]),
            .SETTLE_CYCLES (P_S[i]),
            .ACCUM_CYCLES  (P_A[i]),
            .DATA_W        (16),
            .ACC_W         (P_ACCW[i]),
            .SHIFT         (P_SH[i])
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .stop       (stop),
            .continuous (continuous),
            .mixed      (mixed),
            .row        (o_row[i]),
            .col        (o_col[i]),
            .uplex      (o_uplex[i]),
            .uinput     (o_uinput[i]),
            .wr_en      (o_wr_en[i]),
            .wr_addr    (o_wr_addr[i]),
            .wr_data    (o_wr_data[i]),
            .busy       (o_busy[i]),
            .frame_done (o_fd[i])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    int sel = 0;

    bit  m_active;
    int  m_pos;
    bit  m_stop_req;
    int  hist [$];

    logic        exp_busy, exp_wr, exp_fd;
    logic [2:0]  exp_row, exp_col;
    logic [1:0]  exp_uplex;
    logic [3:0]  exp_uinput;
    logic [5:0]  exp_addr;
    logic [15:0] exp_data;

    // Expected outputs from the position inside the element stream: every element is
    // S settle + A integrate + 1 write cycles, and the write carries the last A samples.
    task automatic update_expected();
        int per, n, ph, e;
        longint s, acc_max;
        per = P_S[sel] + P_A[sel] + 1;
        n = P_ROWS[sel] * P_COLS[sel];
        exp_busy = m_active;
        exp_wr = 1'b0;
        exp_fd = 1'b0;
        if (m_active) begin
            ph = m_pos % per;
            e = (m_pos / per) % n;
            exp_row = 3'(e / P_COLS[sel]);
            exp_col = 3'(e % P_COLS[sel]);
            exp_addr = 6'(e);
            if (ph == per - 1) begin
                exp_wr = 1'b1;
                exp_fd = (e == n - 1);
                s = 0;
                for (int j = 0; j < P_A[sel]; j++)
                    s += longint'(hist[hist.size() - 1 - j]);
                acc_max = (longint'(1) << P_ACCW[sel]) - 1;
                if (s > acc_max) s = acc_max;
                s = s >> P_SH[sel];
                if (s > 65535) s = 65535;
                exp_data = 16'(s);
            end
        end
        exp_uplex = 2'(3 - int'(exp_row) / 2);
        exp_uinput = 4'(int'(exp_col) + (int'(exp_row) % 2) * 9);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pos = 0;
        m_stop_req = 1'b0;
        exp_row = '0;
        exp_col = '0;
        update_expected();
    endtask

    task automatic model_edge(input logic st, input logic sp, input logic cont, input logic [15:0] mx);
        int per, n, ph, e;
        per = P_S[sel] + P_A[sel] + 1;
        n = P_ROWS[sel] * P_COLS[sel];
        hist.push_back(int'(mx));
        if (hist.size() > 16) void'(hist.pop_front());
        if (!m_active) begin
            m_stop_req = 1'b0;
            if (st && !sp) begin
                m_active = 1'b1;
                m_pos = 0;
            end
        end else begin
            ph = m_pos % per;
            e = (m_pos / per) % n;
            if (sp) m_stop_req = 1'b1;
            if (ph == per - 1 && (m_stop_req || (e == n - 1 && !cont))) begin
                m_active = 1'b0;
                m_stop_req = 1'b0;
            end else begin
                m_pos++;
            end
        end
        update_expected();
    endtask

    task automatic tick(input logic st, input logic sp, input logic cont, input logic [15:0] mx);
        start = st;
        stop = sp;
        continuous = cont;
        mixed = mx;
        @(posedge clk);
        model_edge(st, sp, cont, mx);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        continuous = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if ({o_busy[i], o_wr_en[i], o_fd[i], o_row[i], o_col[i], o_wr_addr[i], o_wr_data[i]} !== 31'd0) begin
                n_bad++;
                $display("[TB] FAIL reset_state dut%0d: got %h want 0", i,
                         {o_busy[i], o_wr_en[i], o_fd[i], o_row[i], o_col[i], o_wr_addr[i], o_wr_data[i]});
            end
            n_cmp++;
            if ({o_uplex[i], o_uinput[i]} !== {2'd3, 4'd0}) begin
                n_bad++;
                $display("[TB] FAIL reset_map dut%0d: got %h want %h", i, {o_uplex[i], o_uinput[i]}, {2'd3, 4'd0});
            end
        end
    endtask

    task automatic test_single_frame();
        int n_wr, lat;
        logic [15:0] mx;
        sel = 0;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            n_wr = 0;
            lat = -1;
            mx = (pass == 0) ? 16'd100 : 16'($urandom);
            tick(1'b1, 1'b0, 1'b0, mx);
            for (int c = 0; c < 6 * 13 + 10; c++) begin
                mx = (pass == 0) ? 16'd100 : 16'($urandom);
                tick(1'b0, 1'b0, 1'b0, mx);
                if (o_wr_en[sel] === 1'b1) begin
                    n_wr++;
                    if (lat < 0) lat = c + 2;
                end
                n_cmp++;
                if ({o_busy[sel], o_wr_en[sel], o_fd[sel]} !== {exp_busy, exp_wr, exp_fd}) begin
                    n_bad++;
                    $display("[TB] FAIL frame_ctl cyc %0d: got %b want %b", c, {o_busy[sel], o_wr_en[sel], o_fd[sel]}, {exp_busy, exp_wr, exp_fd});
                end
                if (exp_wr) begin
                    n_cmp++;
                    if ({o_wr_addr[sel], o_wr_data[sel]} !== {exp_addr, exp_data}) begin
                        n_bad++;
                        $display("[TB] FAIL frame_write cyc %0d: got addr %0d data %0d want addr %0d data %0d", c, o_wr_addr[sel], o_wr_data[sel], exp_addr, exp_data);
                    end
                end
            end
            n_cmp++;
            if (n_wr != 6 || lat != 13) begin
                n_bad++;
                $display("[TB] FAIL frame_count: got %0d writes latency %0d want 6 writes latency 13", n_wr, lat);
            end
        end
    endtask

    task automatic test_saturation();
        for (int s = 1; s <= 2; s++) begin
            sel = s;
            do_reset();
            tick(1'b1, 1'b0, 1'b0, 16'hFFFF);
            for (int c = 0; c < 6 * 13 + 5; c++) begin
                tick(1'b0, 1'b0, 1'b0, 16'hFFFF);
                n_cmp++;
                if ({o_busy[sel], o_wr_en[sel], o_fd[sel]} !== {exp_busy, exp_wr, exp_fd}) begin
                    n_bad++;
                    $display("[TB] FAIL sat_ctl dut%0d cyc %0d: got %b want %b", s, c, {o_busy[sel], o_wr_en[sel], o_fd[sel]}, {exp_busy, exp_wr, exp_fd});
                end
                if (exp_wr) begin
                    n_cmp++;
                    if ({o_wr_addr[sel], o_wr_data[sel]} !== {exp_addr, 16'hFFFF}) begin
                        n_bad++;
                        $display("[TB] FAIL sat_write dut%0d cyc %0d: got addr %0d data %h want addr %0d data ffff", s, c, o_wr_addr[sel], o_wr_data[sel], exp_addr);
                    end
                end
            end
        end
    endtask

    task automatic test_mapping();
        sel = 3;
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 16'($urandom));
        for (int c = 0; c < 49 * 6 + 5; c++) begin
            tick(1'b0, 1'b0, 1'b0, 16'($urandom));
            n_cmp++;
            if ({o_busy[sel], o_wr_en[sel], o_fd[sel]} !== {exp_busy, exp_wr, exp_fd}) begin
                n_bad++;
                $display("[TB] FAIL map_ctl cyc %0d: got %b want %b", c, {o_busy[sel], o_wr_en[sel], o_fd[sel]}, {exp_busy, exp_wr, exp_fd});
            end
            if (exp_busy) begin
                n_cmp++;
                if ({o_row[sel], o_col[sel], o_uplex[sel], o_uinput[sel]} !== {exp_row, exp_col, exp_uplex, exp_uinput}) begin
                    n_bad++;
                    $display("[TB] FAIL map_elem cyc %0d: got r%0d c%0d p%0d i%0d want r%0d c%0d p%0d i%0d", c,
                             o_row[sel], o_col[sel], o_uplex[sel], o_uinput[sel], exp_row, exp_col, exp_uplex, exp_uinput);
                end
            end
            if (exp_wr) begin
                n_cmp++;
                if ({o_wr_addr[sel], o_wr_data[sel]} !== {exp_addr, exp_data}) begin
                    n_bad++;
                    $display("[TB] FAIL map_write cyc %0d: got addr %0d data %0d want addr %0d data %0d", c, o_wr_addr[sel], o_wr_data[sel], exp_addr, exp_data);
                end
            end
            if (exp_busy && exp_row == 3'd5 && exp_col == 3'd4) begin
                n_cmp++;
                if ({o_uplex[sel], o_uinput[sel]} !== {2'd1, 4'd13}) begin
                    n_bad++;
                    $display("[TB] FAIL map_r5c4: got p%0d i%0d want p1 i13", o_uplex[sel], o_uinput[sel]);
                end
            end
            if (exp_busy && exp_row == 3'd6 && exp_col == 3'd6) begin
                n_cmp++;
                if ({o_uplex[sel], o_uinput[sel]} !== {2'd0, 4'd6}) begin
                    n_bad++;
                    $display("[TB] FAIL map_r6c6: got p%0d i%0d want p0 i6", o_uplex[sel], o_uinput[sel]);
                end
            end
        end
    endtask

    task automatic test_continuous_stop();
        int n_wr, n_fd;
        logic sp;
        sel = 0;
        do_reset();
        n_wr = 0;
        n_fd = 0;
        tick(1'b1, 1'b0, 1'b1, 16'($urandom));
        for (int c = 0; c < 2 * 6 * 13 + 20; c++) begin
            sp = m_active && (m_pos == 8 * 13 + 4 + 2);
            tick(1'b0, sp, 1'b1, 16'($urandom));
            if (o_wr_en[sel] === 1'b1) n_wr++;
            if (o_fd[sel] === 1'b1) n_fd++;
            n_cmp++;
            if ({o_busy[sel], o_wr_en[sel], o_fd[sel]} !== {exp_busy, exp_wr, exp_fd}) begin
                n_bad++;
                $display("[TB] FAIL cont_ctl cyc %0d: got %b want %b", c, {o_busy[sel], o_wr_en[sel], o_fd[sel]}, {exp_busy, exp_wr, exp_fd});
            end
            if (exp_wr) begin
                n_cmp++;
                if ({o_wr_addr[sel], o_wr_data[sel]} !== {exp_addr, exp_data}) begin
                    n_bad++;
                    $display("[TB] FAIL cont_write cyc %0d: got addr %0d data %0d want addr %0d data %0d", c, o_wr_addr[sel], o_wr_data[sel], exp_addr, exp_data);
                end
            end
        end
        n_cmp++;
        if (n_wr != 9 || n_fd != 1) begin
            n_bad++;
            $display("[TB] FAIL cont_stop_count: got %0d writes %0d frame_done want 9 writes 1 frame_done", n_wr, n_fd);
        end
    endtask

    task automatic test_async_reset();
        int n_wr;
        sel = 0;
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 16'($urandom));
        repeat (8) tick(1'b0, 1'b0, 1'b0, 16'($urandom));
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_busy[sel], o_wr_en[sel], o_fd[sel], o_row[sel], o_col[sel], o_wr_addr[sel], o_wr_data[sel], o_uplex[sel], o_uinput[sel]}
            !== {31'd0, 2'd3, 4'd0}) begin
            n_bad++;
            $display("[TB] FAIL async_reset: got %h want %h",
                     {o_busy[sel], o_wr_en[sel], o_fd[sel], o_row[sel], o_col[sel], o_wr_addr[sel], o_wr_data[sel], o_uplex[sel], o_uinput[sel]},
                     {31'd0, 2'd3, 4'd0});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_wr = 0;
        for (int c = 0; c < 40; c++) begin
            tick(c == 20, 1'b0, 1'b0, 16'($urandom));
            if (o_wr_en[sel] === 1'b1) n_wr++;
            n_cmp++;
            if ({o_busy[sel], o_wr_en[sel], o_fd[sel]} !== {exp_busy, exp_wr, exp_fd}) begin
                n_bad++;
                $display("[TB] FAIL rst_ctl cyc %0d: got %b want %b", c, {o_busy[sel], o_wr_en[sel], o_fd[sel]}, {exp_busy, exp_wr, exp_fd});
            end
            if (exp_wr) begin
                n_cmp++;
                if ({o_wr_addr[sel], o_wr_data[sel]} !== {6'd0, exp_data}) begin
                    n_bad++;
                    $display("[TB] FAIL rst_first_write: got addr %0d data %0d want addr 0 data %0d", o_wr_addr[sel], o_wr_data[sel], exp_data);
                end
            end
        end
        n_cmp++;
        if (n_wr != 1) begin
            n_bad++;
            $display("[TB] FAIL rst_write_count: got %0d want 1", n_wr);
        end
    endtask

    task automatic test_start_ignored();
        int n_wr;
        logic st, sp, ct;
        sel = 0;
        do_reset();
        n_wr = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1'b1, 1'b1, 1'b0, 16'($urandom));
            n_cmp++;
            if ({o_busy[sel], o_wr_en[sel]} !== 2'b00) begin
                n_bad++;
                $display("[TB] FAIL start_with_stop cyc %0d: got %b want 00", c, {o_busy[sel], o_wr_en[sel]});
            end
        end
        tick(1'b1, 1'b0, 1'b0, 16'($urandom));
        for (int c = 0; c < 6 * 13 + 10; c++) begin
            tick(c < 6 * 13 - 2, 1'b0, 1'b0, 16'($urandom));
            if (o_wr_en[sel] === 1'b1) n_wr++;
            n_cmp++;
            if ({o_busy[sel], o_wr_en[sel], o_fd[sel]} !== {exp_busy, exp_wr, exp_fd}) begin
                n_bad++;
                $display("[TB] FAIL held_start_ctl cyc %0d: got %b want %b", c, {o_busy[sel], o_wr_en[sel], o_fd[sel]}, {exp_busy, exp_wr, exp_fd});
            end
            if (exp_wr) begin
                n_cmp++;
                if ({o_wr_addr[sel], o_wr_data[sel]} !== {exp_addr, exp_data}) begin
                    n_bad++;
                    $display("[TB] FAIL held_start_write cyc %0d: got addr %0d data %0d want addr %0d data %0d", c, o_wr_addr[sel], o_wr_data[sel], exp_addr, exp_data);
                end
            end
        end
        n_cmp++;
        if (n_wr != 6) begin
            n_bad++;
            $display("[TB] FAIL held_start_count: got %0d want 6", n_wr);
        end
        // Free-running random control to shake out stop/continuous/start interactions.
        for (int c = 0; c < 3 * 6 * 13; c++) begin
            st = 1'($urandom_range(0, 1));
            sp = ($urandom_range(0, 19) == 0);
            ct = 1'($urandom_range(0, 1));
            tick(st, sp, ct, 16'($urandom));
            n_cmp++;
            if ({o_busy[sel], o_wr_en[sel], o_fd[sel]} !== {exp_busy, exp_wr, exp_fd}) begin
                n_bad++;
                $display("[TB] FAIL random_ctl cyc %0d: got %b want %b", c, {o_busy[sel], o_wr_en[sel], o_fd[sel]}, {exp_busy, exp_wr, exp_fd});
            end
            if (exp_wr) begin
                n_cmp++;
                if ({o_wr_addr[sel], o_wr_data[sel]} !== {exp_addr, exp_data}) begin
                    n_bad++;
                    $display("[TB] FAIL random_write cyc %0d: got addr %0d data %0d want addr %0d data %0d", c, o_wr_addr[sel], o_wr_data[sel], exp_addr, exp_data);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_saturation();
        test_mapping();
        test_continuous_stop();
        test_async_reset();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
